// File: rtl/vga_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// vga_rd_arbiter_if
// One AXI4 read-channel bundle: AR request channel plus R data channel.
//   master modport : issues AR requests and accepts R beats (request initiator)
//   slave  modport : accepts AR requests and returns R beats (request target)
// Parameters ADDR_W / DATA_W / ID_W size the address, data and ID fields.
// ----------------------------------------------------------------------------
interface vga_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic [ID_W-1:0]   ar_id;
    logic              ar_valid;
    logic              ar_ready;

    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic [ID_W-1:0]   r_id;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;

    modport master (
        output ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_id, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_id, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/vga_rd_arbiter.sv
// ----------------------------------------------------------------------------
// vga_rd_arbiter
// 2:1 AXI4 read arbiter sharing one memory read port between the VGA
// framebuffer DMA (port 0, fixed high priority) and a secondary reader
// (port 1). A starvation counter forces a port-1 grant after STARVE_LIMIT
// consecutive port-0 grants taken while port 1 was waiting. Exactly one
// transaction is outstanding at a time and bursts are never interleaved.
//
// Ports:
//   aclk     clock
//   aresetn  synchronous active-low reset
//   s0, s1   upstream read ports (slave side of the bundle)
//   m        downstream read port to the interconnect (master side)
//   busy     high while a transaction is in the ADDR or DATA phase
//   grant    port currently / most recently granted
//   err_len  sticky flag: burst beat count disagreed with the requested length
// ----------------------------------------------------------------------------
module vga_rd_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    vga_rd_arbiter_if.slave     s0,
    vga_rd_arbiter_if.slave     s1,
    vga_rd_arbiter_if.master    m,
    output logic                busy,
    output logic                grant,
    output logic                err_len
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              grant_reg;
    logic [7:0]        starve_cnt_reg;
    logic [7:0]        beat_cnt_reg;
    logic              err_len_reg;

    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [ID_W-1:0]   id_reg;

    logic              any_valid;
    logic              sel;
    logic              accept;
    logic              r_beat;
    logic              up_r_ready;
    logic [1:0]        up_r_ready_vec;
    logic [1:0]        r_valid_vec;

    // Port 1 wins only when port 0 is absent or port 1 has waited long enough.
    assign any_valid = s0.ar_valid | s1.ar_valid;
    assign sel       = s1.ar_valid & (~s0.ar_valid | (starve_cnt_reg == LIMIT));
    // No request is taken while reset is asserted, so nothing upstream ever
    // sees an accept that the datapath would then discard.
    assign accept    = aresetn & (state_reg == IDLE) & any_valid;

    // Read beat routing: only the granted port sees r_valid, and only its
    // r_ready is fed back downstream.
    assign up_r_ready_vec = {s1.r_ready, s0.r_ready};
    assign up_r_ready     = up_r_ready_vec[grant_reg];
    assign r_beat         = (state_reg == DATA) & m.r_valid & up_r_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign r_valid_vec[gi] = (state_reg == DATA) & (grant_reg == 1'(gi)) & m.r_valid;
        end
    endgenerate

    assign s0.r_valid = r_valid_vec[0];
    assign s1.r_valid = r_valid_vec[1];

    // Data fields go to both ports unchanged; r_valid qualifies them.
    assign s0.r_data  = m.r_data;
    assign s0.r_resp  = m.r_resp;
    assign s0.r_id    = m.r_id;
    assign s0.r_last  = m.r_last;
    assign s1.r_data  = m.r_data;
    assign s1.r_resp  = m.r_resp;
    assign s1.r_id    = m.r_id;
    assign s1.r_last  = m.r_last;

    assign m.ar_addr  = addr_reg;
    assign m.ar_len   = len_reg;
    assign m.ar_size  = size_reg;
    assign m.ar_burst = burst_reg;
    assign m.ar_id    = id_reg;

    assign grant      = grant_reg;
    assign err_len    = err_len_reg;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)                   state_next = ADDR;
            ADDR:    if (m.ar_ready)               state_next = DATA;
            DATA:    if (r_beat && m.r_last)       state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s0.ar_ready = 1'b0;
        s1.ar_ready = 1'b0;
        m.ar_valid  = 1'b0;
        m.r_ready   = 1'b0;
        busy        = 1'b0;
        case (state_reg)
            IDLE: begin
                s0.ar_ready = accept & ~sel;
                s1.ar_ready = accept & sel;
            end
            ADDR: begin
                m.ar_valid = 1'b1;
                busy       = 1'b1;
            end
            DATA: begin
                m.r_ready  = up_r_ready;
                busy       = 1'b1;
            end
            default: begin
                busy       = 1'b0;
            end
        endcase
    end

    // ---------------- datapath: request latch, counters, error flag ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            grant_reg      <= 1'b0;
            starve_cnt_reg <= 8'd0;
            beat_cnt_reg   <= 8'd0;
            err_len_reg    <= 1'b0;
            addr_reg       <= '0;
            len_reg        <= 8'd0;
            size_reg       <= 3'd0;
            burst_reg      <= 2'd0;
            id_reg         <= '0;
        end else begin
            if (state_reg == IDLE) begin
                // The counter measures how long port 1 has been waiting, so
                // any idle cycle without a port-1 request restarts it.
                if (!s1.ar_valid) begin
                    starve_cnt_reg <= 8'd0;
                end else if (accept) begin
                    if (sel) begin
                        starve_cnt_reg <= 8'd0;
                    end else if (starve_cnt_reg != LIMIT) begin
                        starve_cnt_reg <= starve_cnt_reg + 8'd1;
                    end
                end

                if (accept) begin
                    grant_reg <= sel;
                    addr_reg  <= sel ? s1.ar_addr  : s0.ar_addr;
                    len_reg   <= sel ? s1.ar_len   : s0.ar_len;
                    size_reg  <= sel ? s1.ar_size  : s0.ar_size;
                    burst_reg <= sel ? s1.ar_burst : s0.ar_burst;
                    id_reg    <= sel ? s1.ar_id    : s0.ar_id;
                end
            end

            if ((state_reg == ADDR) && m.ar_ready) begin
                beat_cnt_reg <= 8'd0;
            end

            if (r_beat) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
                // Early last, or the final expected beat arriving without last.
                if ((m.r_last && (beat_cnt_reg != len_reg)) ||
                    (!m.r_last && (beat_cnt_reg == len_reg))) begin
                    err_len_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rd_arbiter.sv
module tb_vga_rd_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int LIM = 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic busy;
    logic grant;
    logic err_len;

    vga_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s0_bus ();
    vga_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s1_bus ();
    vga_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m_bus ();

    vga_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .STARVE_LIMIT(LIM)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0      (s0_bus),
        .s1      (s1_bus),
        .m       (m_bus),
        .busy    (busy),
        .grant   (grant),
        .err_len (err_len)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
    } req_t;

    typedef struct {
        logic v0;
        logic v1;
        req_t r0;
        req_t r1;
        int   last_at;   // -1: last on beat len, else beat index carrying r_last
        int   ar_delay;
        int   rmode;     // 0 always ready, 1 random ready, 2 toggling ready
        bit   rst_before;
        int   exp_sel;
        logic exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        @(negedge aclk);
    endtask

    function automatic logic [31:0] beat_data(input req_t r, input int b);
        return r.addr ^ (32'(b) << 8) ^ {28'h0, r.id} ^ 32'h5A00_0000;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.addr  = $urandom;
        r.len   = 8'($urandom_range(5));
        r.size  = 3'($urandom_range(7));
        r.burst = 2'($urandom_range(2));
        r.id    = 4'($urandom_range(15));
        return r;
    endfunction

    task automatic clear_inputs();
        s0_bus.ar_valid = 1'b0; s1_bus.ar_valid = 1'b0;
        s0_bus.ar_addr = '0; s0_bus.ar_len = '0; s0_bus.ar_size = '0; s0_bus.ar_burst = '0; s0_bus.ar_id = '0;
        s1_bus.ar_addr = '0; s1_bus.ar_len = '0; s1_bus.ar_size = '0; s1_bus.ar_burst = '0; s1_bus.ar_id = '0;
        s0_bus.r_ready = 1'b0; s1_bus.r_ready = 1'b0;
        m_bus.ar_ready = 1'b0; m_bus.r_valid = 1'b0; m_bus.r_last = 1'b0;
        m_bus.r_data = '0; m_bus.r_resp = '0; m_bus.r_id = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        step();
        aresetn = 1'b1;
        settle();
        chk("rst_err_len", 64'(err_len), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        step();
    endtask

    // One complete transaction starting in an IDLE cycle; returns in the first
    // IDLE cycle after the last beat so back-to-back calls test back-to-back accepts.
    task automatic do_txn(input logic v0, input logic v1, input req_t r0, input req_t r1,
                          input int exp_sel, input int last_at, input int ar_delay,
                          input int rmode, input bit keep);
        req_t        rq;
        int          nbeats;
        logic [48:0] exp_f;
        logic        rdy;
        rq = (exp_sel == 1) ? r1 : r0;
        s0_bus.ar_addr = r0.addr; s0_bus.ar_len = r0.len; s0_bus.ar_size = r0.size;
        s0_bus.ar_burst = r0.burst; s0_bus.ar_id = r0.id; s0_bus.ar_valid = v0;
        s1_bus.ar_addr = r1.addr; s1_bus.ar_len = r1.len; s1_bus.ar_size = r1.size;
        s1_bus.ar_burst = r1.burst; s1_bus.ar_id = r1.id; s1_bus.ar_valid = v1;
        settle();
        chk("busy_idle", 64'(busy), 64'(0));
        chk("s0_ar_ready", 64'(s0_bus.ar_ready), 64'(exp_sel == 0));
        chk("s1_ar_ready", 64'(s1_bus.ar_ready), 64'(exp_sel == 1));
        step();
        if (!keep) begin
            if (exp_sel == 0) s0_bus.ar_valid = 1'b0;
            else              s1_bus.ar_valid = 1'b0;
        end
        exp_f = {rq.addr, rq.len, rq.size, rq.burst, rq.id};
        for (int c = 0; c <= ar_delay; c++) begin
            m_bus.ar_ready = (c == ar_delay);
            settle();
            chk("m_ar_valid", 64'(m_bus.ar_valid), 64'(1));
            chk("m_ar_fields", 64'({m_bus.ar_addr, m_bus.ar_len, m_bus.ar_size, m_bus.ar_burst, m_bus.ar_id}), 64'(exp_f));
            chk("grant", 64'(grant), 64'(exp_sel));
            chk("ar_ready_busy", 64'({s1_bus.ar_ready, s0_bus.ar_ready}), 64'(0));
            step();
        end
        m_bus.ar_ready = 1'b0;
        nbeats = (last_at >= 0) ? last_at + 1 : int'(rq.len) + 1;
        for (int b = 0; b < nbeats; b++) begin
            if (rmode == 1 && $urandom_range(3) == 0) begin
                m_bus.r_valid = 1'b0;
                settle();
                chk("r_valid_gap", 64'({s1_bus.r_valid, s0_bus.r_valid}), 64'(0));
                step();
            end
            m_bus.r_valid = 1'b1;
            m_bus.r_data  = beat_data(rq, b);
            m_bus.r_resp  = 2'(b);
            m_bus.r_id    = rq.id;
            m_bus.r_last  = (b == nbeats - 1);
            for (int t = 0; t < 8; t++) begin
                if (rmode == 0)      rdy = 1'b1;
                else if (rmode == 2) rdy = (t % 2 == 1);
                else                 rdy = (t == 7) || ($urandom_range(1) == 1);
                if (exp_sel == 0) begin s0_bus.r_ready = rdy; s1_bus.r_ready = ~rdy; end
                else              begin s1_bus.r_ready = rdy; s0_bus.r_ready = ~rdy; end
                settle();
                chk("m_r_ready", 64'(m_bus.r_ready), 64'(rdy));
                chk("r_valid_route", 64'({s1_bus.r_valid, s0_bus.r_valid}), (exp_sel == 1) ? 64'h2 : 64'h1);
                chk("r_data", 64'((exp_sel == 1) ? s1_bus.r_data : s0_bus.r_data), 64'(beat_data(rq, b)));
                chk("r_last", 64'((exp_sel == 1) ? s1_bus.r_last : s0_bus.r_last), 64'(b == nbeats - 1));
                step();
                if (rdy) break;
            end
        end
        m_bus.r_valid = 1'b0; m_bus.r_last = 1'b0;
        s0_bus.r_ready = 1'b0; s1_bus.r_ready = 1'b0;
    endtask

    localparam int NV = 8;
    vec_t tbl [NV];

    initial begin
        req_t ra, rb, rz;
        int   model_cnt;
        bit   pend0, pend1;
        req_t q0, q1;
        int   esel;

        rz = '{32'h0, 8'd0, 3'd0, 2'd0, 4'd0};
        tbl[0] = '{1'b1, 1'b0, '{32'h1C00_0000, 8'd15, 3'd2, 2'd1, 4'd0}, rz, -1, 0, 0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, rz, '{32'h2000_0040, 8'd3, 3'd2, 2'd1, 4'd5}, -1, 1, 0, 1'b0, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, '{32'h1C00_1000, 8'd0, 3'd2, 2'd1, 4'd3},
                               '{32'h3000_0000, 8'd0, 3'd2, 2'd1, 4'd9}, -1, 0, 0, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, rz, '{32'h3000_0100, 8'd7, 3'd2, 2'd1, 4'd7}, -1, 5, 2, 1'b0, 1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, '{32'h1C00_2000, 8'd2, 3'd2, 2'd1, 4'd1}, rz, 3, 0, 0, 1'b0, 0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, rz, '{32'h3000_0200, 8'd7, 3'd2, 2'd1, 4'd2}, 2, 0, 0, 1'b1, 1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, '{32'h1C00_3000, 8'd1, 3'd2, 2'd1, 4'd4}, rz, -1, 0, 0, 1'b0, 0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, rz, '{32'h3000_0300, 8'd4, 3'd1, 2'd2, 4'd8}, -1, 2, 1, 1'b0, 1, 1'b1};

        // ---- reset state, with requests and a spurious beat present ----
        clear_inputs();
        s0_bus.ar_valid = 1'b1; s1_bus.ar_valid = 1'b1; m_bus.r_valid = 1'b1;
        step();
        settle();
        chk("rst_ar_ready", 64'({s1_bus.ar_ready, s0_bus.ar_ready}), 64'(0));
        chk("rst_m_ar_valid", 64'(m_bus.ar_valid), 64'(0));
        chk("rst_m_r_ready", 64'(m_bus.r_ready), 64'(0));
        chk("rst_r_valid", 64'({s1_bus.r_valid, s0_bus.r_valid}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_err_len", 64'(err_len), 64'(0));
        chk("rst_m_ar_addr", 64'(m_bus.ar_addr), 64'(0));
        step();
        s0_bus.ar_valid = 1'b0; s1_bus.ar_valid = 1'b0;
        aresetn = 1'b1;
        settle();
        chk("spurious_m_r_ready", 64'(m_bus.r_ready), 64'(0));
        chk("spurious_r_valid", 64'({s1_bus.r_valid, s0_bus.r_valid}), 64'(0));
        step();
        m_bus.r_valid = 1'b0;

        // ---- table-driven transactions ----
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst_before) do_reset();
            do_txn(tbl[i].v0, tbl[i].v1, tbl[i].r0, tbl[i].r1, tbl[i].exp_sel,
                   tbl[i].last_at, tbl[i].ar_delay, tbl[i].rmode, 1'b0);
            s0_bus.ar_valid = 1'b0; s1_bus.ar_valid = 1'b0;
            settle();
            chk("tbl_err_len", 64'(err_len), 64'(tbl[i].exp_err));
            $display("row %0d sel=%0d err_len=%0b", i, tbl[i].exp_sel, err_len);
            step();
        end

        // ---- starvation: both ports always valid, len=0 ----
        ra = '{32'h1C00_4000, 8'd0, 3'd2, 2'd1, 4'd1};
        rb = '{32'h3000_4000, 8'd0, 3'd2, 2'd1, 4'd6};
        for (int k = 0; k < 2 * (LIM + 1) + 2; k++) begin
            esel = (k % (LIM + 1) == LIM) ? 1 : 0;
            do_txn(1'b1, 1'b1, ra, rb, esel, -1, 0, 0, 1'b1);
            $display("starve grant %0d expected port %0d", k, esel);
        end
        s0_bus.ar_valid = 1'b0; s1_bus.ar_valid = 1'b0;
        step();

        // ---- back-to-back port-0 requests ----
        do_txn(1'b1, 1'b0, '{32'h1C00_5000, 8'd2, 3'd2, 2'd1, 4'd2}, rz, 0, -1, 0, 0, 1'b0);
        do_txn(1'b1, 1'b0, '{32'h1C00_6000, 8'd1, 3'd2, 2'd1, 4'd3}, rz, 0, -1, 0, 0, 1'b0);
        $display("back-to-back pair done");

        // ---- reset during beat 5 of a 16-beat burst ----
        ra = '{32'h1C00_7000, 8'd15, 3'd2, 2'd1, 4'd0};
        s0_bus.ar_addr = ra.addr; s0_bus.ar_len = ra.len; s0_bus.ar_size = ra.size;
        s0_bus.ar_burst = ra.burst; s0_bus.ar_id = ra.id; s0_bus.ar_valid = 1'b1;
        step();
        s0_bus.ar_valid = 1'b0;
        m_bus.ar_ready = 1'b1;
        step();
        m_bus.ar_ready = 1'b0;
        s0_bus.r_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_bus.r_valid = 1'b1; m_bus.r_data = beat_data(ra, b); m_bus.r_last = 1'b0;
            step();
        end
        settle();
        chk("mid_busy", 64'(busy), 64'(1));
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        settle();
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_r_valid", 64'({s1_bus.r_valid, s0_bus.r_valid}), 64'(0));
        chk("post_rst_m_r_ready", 64'(m_bus.r_ready), 64'(0));
        chk("post_rst_m_ar_valid", 64'(m_bus.ar_valid), 64'(0));
        chk("post_rst_ar_ready", 64'({s1_bus.ar_ready, s0_bus.ar_ready}), 64'(0));
        chk("post_rst_err_len", 64'(err_len), 64'(0));
        chk("post_rst_grant", 64'(grant), 64'(0));
        $display("reset mid-burst applied");
        step();
        clear_inputs();
        do_txn(1'b0, 1'b1, rz, '{32'h3000_8000, 8'd3, 3'd2, 2'd1, 4'd11}, 1, -1, 0, 0, 1'b0);

        // ---- randomized traffic against a transaction-level model ----
        model_cnt = 0;
        pend0 = 1'b0; pend1 = 1'b0;
        q0 = rz; q1 = rz;
        for (int n = 0; n < 60; n++) begin
            if (!pend0 && $urandom_range(1) == 1) begin pend0 = 1'b1; q0 = rand_req(); end
            if (!pend1 && $urandom_range(1) == 1) begin pend1 = 1'b1; q1 = rand_req(); end
            if (!pend0 && !pend1) begin pend0 = 1'b1; q0 = rand_req(); end
            if ($urandom_range(3) == 0) begin
                s0_bus.ar_valid = 1'b0; s1_bus.ar_valid = 1'b0;
                m_bus.r_valid = 1'b1;
                settle();
                chk("idle_spurious_ready", 64'(m_bus.r_ready), 64'(0));
                chk("idle_spurious_valid", 64'({s1_bus.r_valid, s0_bus.r_valid}), 64'(0));
                step();
                m_bus.r_valid = 1'b0;
                model_cnt = 0;
            end
            // Port 1 is served when port 0 is idle or when it has already
            // been passed over LIM times in a row.
            esel = (pend1 && (!pend0 || model_cnt == LIM)) ? 1 : 0;
            if (!pend1)        model_cnt = 0;
            else if (esel == 1) model_cnt = 0;
            else               model_cnt = (model_cnt + 1 > LIM) ? LIM : model_cnt + 1;
            do_txn(pend0, pend1, q0, q1, esel, -1, $urandom_range(2), 1, 1'b0);
            $display("rand txn %0d port %0d len %0d", n, esel, (esel == 1) ? q1.len : q0.len);
            if (esel == 1) pend1 = 1'b0;
            else           pend0 = 1'b0;
        end
        s0_bus.ar_valid = 1'b0; s1_bus.ar_valid = 1'b0;
        settle();
        chk("rand_err_len", 64'(err_len), 64'(0));
        chk("rand_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/vga_rd_arbiter.md
Name: vga_rd_arbiter

Overview:
- 2:1 AXI4 read-channel arbiter. Shares one memory read port between the VGA framebuffer DMA master (port 0, real-time, high priority) and a secondary reader, CPU/blitter (port 1).
- Output feeds the SoC memory interconnect.
- Priority is fixed to port 0, with a starvation counter that guarantees port 1 progress.
- One outstanding transaction at a time; bursts are never interleaved.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- ID_W, 4, AXI ID width, identical on all ports
- STARVE_LIMIT, 8, consecutive port-0 grants allowed while port 1 waits (legal range 1..255)

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s0_ar_addr / s1_ar_addr  in  ADDR_W  request address, ports 0/1
- s0_ar_len / s1_ar_len  in  8  burst length-1
- s0_ar_size / s1_ar_size  in  3  beat size
- s0_ar_burst / s1_ar_burst  in  2  burst type
- s0_ar_id / s1_ar_id  in  ID_W  request ID
- s0_ar_valid / s1_ar_valid  in  1  request valid
- s0_ar_ready / s1_ar_ready  out  1  request accepted
- s0_r_data / s1_r_data  out  DATA_W  read data
- s0_r_resp / s1_r_resp  out  2  read response
- s0_r_id / s1_r_id  out  ID_W  read ID
- s0_r_last / s1_r_last  out  1  last beat
- s0_r_valid / s1_r_valid  out  1  data valid
- s0_r_ready / s1_r_ready  in  1  data ready
- m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_id  out  ADDR_W/8/3/2/ID_W  downstream request fields (registered)
- m_ar_valid  out  1  downstream request valid
- m_ar_ready  in  1  downstream request ready
- m_r_data, m_r_resp, m_r_id, m_r_last  in  DATA_W/2/ID_W/1  downstream read data
- m_r_valid  in  1  downstream data valid
- m_r_ready  out  1  downstream data ready
- busy  out  1  high in ADDR or DATA state
- grant  out  1  current/last granted port (0/1)
- err_len  out  1  sticky: burst beat count mismatched the requested length

Behaviour:
- Reset (aresetn low at posedge): state=IDLE, grant=0, starve_cnt=0, err_len=0. All *_valid and *_ready outputs 0; m_ar_* fields 0. Reset mid-burst abandons the transaction; the downstream is reset in the same domain.
- FSM states: IDLE, ADDR, DATA.
- IDLE, port selection: if any sX_ar_valid, sel=1 when s1_ar_valid && (!s0_ar_valid || starve_cnt==STARVE_LIMIT); otherwise sel=0.
- IDLE, accept: s<sel>_ar_ready=1 combinationally in that cycle and the other ar_ready=0. Fields are latched into m_ar_*, grant<=sel, then ->ADDR.
- sX_ar_ready is 0 outside IDLE.
- ADDR: m_ar_valid=1, fields held stable until m_ar_ready; on handshake ->DATA.
- Request latency: upstream accept at cycle N; m_ar_valid rises at N+1.
- DATA, forwarding: m_r_* are forwarded combinationally to port <grant>: s<grant>_r_valid=m_r_valid, m_r_ready=s<grant>_r_ready.
- DATA, data fields: r_data, r_resp, r_id and r_last are passed unchanged, with no response generation. The non-granted port sees r_valid=0.
- DATA, exit: on a beat with m_r_valid&&m_r_ready&&m_r_last ->IDLE.
- Back-to-back: a new accept is possible in the first IDLE cycle, i.e. the cycle after the last beat.
- Starvation counter: on a grant to 0 while s1_ar_valid=1, starve_cnt increments, saturating at STARVE_LIMIT. On a grant to 1, or whenever s1_ar_valid=0 in IDLE, it clears to 0.
- Beat counter: cleared on entry to DATA, increments per handshaked beat.
- err_len set when:
  - a last beat arrives with beat count != latched ar_len, or
  - a beat arrives at beat count == ar_len without m_r_last.
- err_len clears only on reset. Transaction end is still determined by m_r_last.
- Simultaneous s0/s1 valid with starve_cnt<STARVE_LIMIT: port 0 wins.
- m_r_valid in IDLE or ADDR (spurious): m_r_ready=0, ignored.

Test Plan:
- Single s0 request, addr=0x1C00_0000, len=15, id=0: s0_ar_ready one cycle, m_ar_valid next cycle with identical fields. 16 beats routed to s0 only; s0_r_last on beat 16; busy=0 after; err_len=0.
- s0 and s1 continuously valid, STARVE_LIMIT=8, len=0 each: grants follow the pattern 0×8, 1, 0×8, 1…; starve_cnt returns to 0 after each s1 grant.
- Downstream backpressure, m_ar_ready low 5 cycles: m_ar_* stable throughout. Then s1_r_ready toggling: m_r_ready mirrors it; s0_r_valid stays 0.
- Downstream sends r_last on beat 3 of len=7: transaction ends, state IDLE, err_len=1 and remains set across later clean transactions.
- aresetn low for 1 cycle mid-DATA (beat 4 of 16): next cycle all valid/ready outputs 0, state IDLE, starve_cnt=0, err_len=0. A new s1 request is then accepted normally.
- Back-to-back s0 requests: second s0_ar_ready asserted the cycle after the first burst's last beat; m_ar_valid one cycle later.
